// File: rtl/data_memory_if.sv
// Bus bundle for the data memory: store controls, byte address, write data
// and the combinational read word.
interface data_memory_if;
  logic        WE;
  logic [3:0]  BE;
  logic [31:0] A;
  logic [31:0] WD;
  logic [31:0] RD;

  modport master (output WE, output BE, output A, output WD, input RD);
  modport slave  (input WE, input BE, input A, input WD, output RD);
endinterface

// File: rtl/data_memory.sv
// Word-organised data memory with byte-lane write enables.
// Writes land on the rising clock edge. Reads are combinational from the
// addressed word. An asynchronous active-low reset zeroes the whole array.
module data_memory #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  data_memory_if.slave  bus
);

  logic [31:0]   mem_q [DEPTH];
  logic [31:0]   mem_d [DEPTH];
  logic [AW-1:0] idx_s;
  logic [31:0]   rd_s;
  logic          unused_addr_bits_s;

  // Merge write data into the old word, one byte lane per enable bit.
  // Lanes are fixed: no shifting of WD.
  function automatic logic [31:0] merge_lanes(
    input logic [31:0] old_word,
    input logic [31:0] new_word,
    input logic [3:0]  lane_en
  );
    logic [31:0] result;
    result = old_word;
    for (int i = 0; i < 4; i++) begin
      if (lane_en[i]) begin
        result[8*i +: 8] = new_word[8*i +: 8];
      end else begin
        result[8*i +: 8] = old_word[8*i +: 8];
      end
    end
    return result;
  endfunction

  // Word index. Byte-offset and high bits drop out, so addresses alias
  // modulo DEPTH*4 bytes.
  assign idx_s              = bus.A[AW+1:2];
  assign unused_addr_bits_s = ^{bus.A[31:AW+2], bus.A[1:0]};

  // Next-state array: only the addressed word can change, and only when WE is set.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (bus.WE) begin
      mem_d[idx_s] = merge_lanes(mem_q[idx_s], bus.WD, bus.BE);
    end else begin
      mem_d[idx_s] = mem_q[idx_s];
    end
  end

  // Storage array: async clear while rst_n is low, which also drops any write
  // whose edge falls inside reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 32'h0000_0000;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // Combinational read. Forced to zero during reset so RD never shows
  // pre-reset contents.
  always_comb begin
    if (!rst_n) begin
      rd_s = 32'h0000_0000;
    end else begin
      rd_s = mem_q[idx_s];
    end
  end

  assign bus.RD = rd_s;

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: lane writes, lane isolation, BE=0,
// read-only cycles, address aliasing and asynchronous reset.
module tb_data_memory;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  data_memory_if bus ();

  data_memory #(.DEPTH(64), .AW(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] exp);
    n_checks++;
    assert (bus.RD === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, bus.RD, exp);
    end
  endtask

  // One store: drive on the falling edge, sample just after the rising edge.
  task automatic do_write(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
    @(negedge clk);
    bus.A  = a;
    bus.WD = wd;
    bus.BE = be;
    bus.WE = 1'b1;
    @(posedge clk);
    #1;
    bus.WE = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n  = 1'b1;
    bus.WE = 1'b0;
    bus.BE = 4'b0000;
    bus.A  = 32'h0;
    bus.WD = 32'h0;

    // Reset
    #2 rst_n = 1'b0;
    #1 chk("reset_rd_a0", 32'h0000_0000);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("after_reset_a0", 32'h0000_0000);

    // Lane writes
    do_write(32'h0, 32'h0000_00FF, 4'b0001);
    chk("lane0_write", 32'h0000_00FF);
    do_write(32'h0, 32'hFF00_0000, 4'b1000);
    chk("lane3_write", 32'hFF00_00FF);

    // Lane isolation
    do_write(32'h0, 32'hFFFF_FFFF, 4'b0100);
    chk("lane2_write", 32'hFFFF_00FF);
    do_write(32'h0, 32'hFFFF_FFFF, 4'b0010);
    chk("lane1_write", 32'hFFFF_FFFF);
    do_write(32'h0, 32'h1234_5678, 4'b0010);
    chk("lane1_only", 32'hFFFF_56FF);

    // Full word and BE=0
    do_write(32'h4, 32'hFFFF_FF01, 4'b1111);
    chk("full_word_a4", 32'hFFFF_FF01);
    bus.A = 32'h0;
    #1 chk("a0_untouched", 32'hFFFF_56FF);
    do_write(32'h4, 32'h0000_0000, 4'b0000);
    chk("be_zero", 32'hFFFF_FF01);

    // WE=0 keeps memory; read path is combinational
    @(negedge clk);
    bus.WE = 1'b0;
    bus.BE = 4'b1111;
    bus.WD = 32'hDEAD_BEEF;
    bus.A  = 32'h0;
    repeat (3) @(posedge clk);
    #1 chk("we0_a0", 32'hFFFF_56FF);
    bus.A = 32'h4;
    #1 chk("we0_a4_same_cycle", 32'hFFFF_FF01);
    bus.A = 32'h0;
    #1 chk("we0_a0_switch_back", 32'hFFFF_56FF);

    // Read-during-write: old word before the edge, merged word after
    @(negedge clk);
    bus.A  = 32'h8;
    bus.WD = 32'hCAFE_F00D;
    bus.BE = 4'b1111;
    bus.WE = 1'b1;
    #1 chk("rdw_before_edge", 32'h0000_0000);
    @(posedge clk);
    #1 chk("rdw_after_edge", 32'hCAFE_F00D);
    bus.WE = 1'b0;

    // Aliasing and alignment
    bus.A = 32'h9;
    #1 chk("align_a9", 32'hCAFE_F00D);
    bus.A = 32'hA;
    #1 chk("align_a10", 32'hCAFE_F00D);
    bus.A = 32'h8 + 32'd256;
    #1 chk("alias_a264", 32'hCAFE_F00D);

    // Asynchronous reset between edges
    @(negedge clk);
    #2 rst_n = 1'b0;
    bus.A = 32'h0;
    #1 chk("areset_a0", 32'h0000_0000);
    bus.A = 32'h4;
    #1 chk("areset_a4", 32'h0000_0000);
    bus.A = 32'h8;
    #1 chk("areset_a8", 32'h0000_0000);

    // Write attempted while reset is held is dropped
    @(negedge clk);
    bus.A  = 32'h8;
    bus.WD = 32'h1111_1111;
    bus.BE = 4'b1111;
    bus.WE = 1'b1;
    @(posedge clk);
    #1 chk("write_in_reset_rd", 32'h0000_0000);
    @(negedge clk);
    bus.WE = 1'b0;
    rst_n  = 1'b1;
    @(posedge clk);
    #1 chk("write_in_reset_dropped", 32'h0000_0000);
    bus.A = 32'h0;
    #1 chk("post_reset_a0", 32'h0000_0000);

    // Normal operation resumes after reset
    do_write(32'h4, 32'hA5A5_A5A5, 4'b0011);
    chk("post_reset_write", 32'h0000_A5A5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog: the directed sequence is short, so a long run means a hang.
  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/data_memory.md
# data_memory

Word-organised data memory for the processor datapath. Byte-lane write enables allow byte, halfword and word stores. Writes are synchronous on the rising clock edge. Reads are combinational from the addressed word. An asynchronous active-low reset clears the whole array to zero.

## Interface
Parameters:
- DEPTH, default 64: number of 32-bit words stored.
- AW, default 6: word-index width; must equal log2(DEPTH).

Ports:
- clk  input  1: single clock; all writes on rising edge.
- rst_n  input  1: reset, asynchronous, active-low; clears every word to 0.
- WE  input  1: write enable; 1 = store this cycle, 0 = read only.
- BE  input  4: byte-lane enables; BE[i] selects bits [8i+7:8i].
- A  input  32: byte address.
- WD  input  32: write data, lane-aligned.
- RD  output  32: read data, the full word at A.

## Operation
- Storage: DEPTH x 32-bit array mem[0..DEPTH-1].
- Word index = A[AW+1:2].
  - A[1:0] are ignored, so all accesses are word-aligned.
  - A[31:AW+2] are ignored, so addresses alias modulo DEPTH*4 bytes.
- Read: RD = mem[A[AW+1:2]], combinational, regardless of WE and BE.
- Write: on rising clk, when rst_n=1 and WE=1, every lane i with BE[i]=1 takes mem[idx][8i+7:8i] <= WD[8i+7:8i]. Lanes with BE[i]=0 keep their value.
- Lane mapping is fixed with no data shifting. The store unit upstream places byte and halfword data in the correct lane of WD.
  - BE=4'b1000 writes WD[31:24] into bits [31:24].
  - BE=4'b0001 writes WD[7:0] into bits [7:0].
- WE=1 with BE=4'b0000: no lane is written and memory is unchanged.
- WE=0: memory is unchanged whatever BE is.
- Reset:
  - While rst_n=0, every word is forced to 32'h0 immediately, without waiting for clk.
  - RD = 0 for any address during reset.
  - Writes are ignored during reset.
- No X on RD after the first reset. Memory contents before the first reset are undefined.

## Timing
- Write latency: 1 clock. Data presented with WE=1 before a rising edge is stored at that edge.
- Read latency: 0 cycles. RD follows A and memory contents combinationally.
- Read during write to the same word:
  - Before the edge, RD shows the old contents.
  - After the edge, RD shows the merged new word in the same cycle.
  - There is no write-through bypass of WD into RD.
- Reset asserted mid-cycle clears memory at once. A write whose edge coincides with rst_n=0 is dropped.
- Reset deassertion is followed by normal operation starting at the next rising edge.
- Back-to-back writes to the same word with different BE merge cumulatively across cycles.

## Test plan
- Reset, then lane writes:
  - Stimulus: rst_n low then high; WE=1, A=0, WD=32'h000000FF, BE=4'b0001 for one edge.
  - Required: RD=32'h000000FF.
  - Then BE=4'b1000, WD=32'hFF000000; required RD=32'hFF0000FF.
- Lane isolation:
  - Stimulus: A=0, WD=32'hFFFFFFFF, one edge each with BE=4'b0100 then BE=4'b0010, starting from 32'hFF0000FF.
  - Required: RD=32'hFFFFFFFF.
  - A write with WD=32'h12345678, BE=4'b0010 must then give RD=32'hFFFF56FF.
- Full word and BE=0:
  - Stimulus: A=4, WE=1, BE=4'b1111, WD=32'hFFFFFF01 (-255).
  - Required: RD=32'hFFFFFF01 at A=4; A=0 unchanged.
  - Then BE=4'b0000, WD=0; required RD still 32'hFFFFFF01.
- WE=0 / read path:
  - Stimulus: WE=0, BE=4'b1111, WD=32'hDEADBEEF, several edges.
  - Required: no word changes.
  - Changing A between 0 and 4 switches RD within the same cycle.
- Address aliasing and alignment:
  - Stimulus: write 32'hCAFEF00D at A=8; read A=9, A=10 and A=8+DEPTH*4.
  - Required: all return 32'hCAFEF00D.
- Asynchronous reset mid-operation:
  - Stimulus: after the above, pulse rst_n low between clock edges.
  - Required: RD=0 immediately for A=0, 4 and 8.
  - A write with WE=1 at an edge while rst_n=0 leaves the word at 0.
